// File: rtl/move_pulse_gen_if.sv
// move_pulse_gen_if
//   Bundles the controls and pulse outputs of move_pulse_gen.
//   master : the side that drives the controls and reads the pulses (top level / bench).
//   slave  : the generator itself.
// Signals
//   enable    controls -> generator  0 clears all counters and silences move
//   btn       controls -> generator  debounced buttons {right,left,down,up}
//   accel_x   controls -> generator  sign-magnitude tilt, sign 1 = right
//   accel_y   controls -> generator  sign-magnitude tilt, sign 1 = up/forward
//   move      generator -> consumer  one-cycle move pulses {right,left,down,up}
//   level_x   generator -> consumer  current X tilt level (0 when inactive)
//   level_y   generator -> consumer  current Y tilt level (0 when inactive)
//   tilt_act  generator -> consumer  {x_active,y_active}
interface move_pulse_gen_if #(
  parameter int ACC_W = 9
);
  logic             enable;
  logic [3:0]       btn;
  logic [ACC_W-1:0] accel_x;
  logic [ACC_W-1:0] accel_y;
  logic [3:0]       move;
  logic [1:0]       level_x;
  logic [1:0]       level_y;
  logic [1:0]       tilt_act;

  modport master (
    output enable, btn, accel_x, accel_y,
    input  move, level_x, level_y, tilt_act
  );

  modport slave (
    input  enable, btn, accel_x, accel_y,
    output move, level_x, level_y, tilt_act
  );
endinterface

// File: rtl/move_pulse_gen.sv
// move_pulse_gen
//   Turns debounced buttons and sign-magnitude accelerometer tilt into registered
//   one-cycle move pulses for the Ball. Buttons fire on press and then auto-repeat
//   every BTN_PERIOD clocks; tilt fires at a rate that doubles per tilt level.
// Ports
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    move_pulse_gen_if.slave: enable, btn, accel_x/y in; move, level_x/y, tilt_act out
module move_pulse_gen #(
  parameter int ACC_W       = 9,
  parameter int BTN_PERIOD  = 1111111,
  parameter int BASE_PERIOD = 1666666,
  parameter int DEADZONE    = 16,
  parameter int LEVEL_SHIFT = 5,
  parameter int MAX_LEVEL   = 3,
  parameter int CNT_W       = 32,
  parameter int CANCEL_OPP  = 1
) (
  input  logic               clk,
  input  logic               reset,
  move_pulse_gen_if.slave    bus
);

  localparam logic [ACC_W-2:0] DZ      = (ACC_W-1)'(DEADZONE);
  localparam logic [ACC_W-2:0] ML      = (ACC_W-1)'(MAX_LEVEL);
  localparam logic [CNT_W-1:0] BTN_LIM = CNT_W'(BTN_PERIOD - 1);
  localparam logic [CNT_W-1:0] BASE    = CNT_W'(BASE_PERIOD);

  // Only called for active magnitudes, so the subtraction never wraps.
  function automatic logic [1:0] level_of(input logic [ACC_W-2:0] mag);
    logic [ACC_W-2:0] step;
    step = (mag - DZ) >> LEVEL_SHIFT;
    if (step > ML) return ML[1:0];
    return step[1:0];
  endfunction

  // Axis index 0 = X, 1 = Y throughout.
  logic [1:0][ACC_W-1:0] accel;
  assign accel = {bus.accel_y, bus.accel_x};

  logic [1:0]            act_q, act_d, sgn_q, sgn_d;
  logic [1:0]            was_act_q, was_act_d, dir_q, dir_d;
  logic [1:0][1:0]       lvl_q, lvl_d;
  logic [1:0][CNT_W-1:0] tcnt_q, tcnt_d;
  logic [1:0][CNT_W-1:0] period;
  logic [3:0]            tilt_raw;
  logic [3:0][CNT_W-1:0] bcnt_q, bcnt_d;
  logic [3:0]            bprev_q, bprev_d, btn_raw;
  logic [3:0]            move_q, move_d;

  // Tilt decode keeps running while disabled so level/active outputs track the inputs.
  always_comb begin
    act_d = '0;
    sgn_d = '0;
    lvl_d = '0;
    for (int a = 0; a < 2; a++) begin
      act_d[a] = accel[a][ACC_W-2:0] > DZ;
      sgn_d[a] = accel[a][ACC_W-1];
      if (act_d[a]) lvl_d[a] = level_of(accel[a][ACC_W-2:0]);
    end
  end

  // A sign flip is only recognised when the axis was active on both sides of it;
  // the >= compare lets a level increase fire at once on an already-long count.
  always_comb begin
    tcnt_d    = '0;
    tilt_raw  = '0;
    period    = '0;
    was_act_d = act_q;
    dir_d     = sgn_q;
    for (int a = 0; a < 2; a++) begin
      period[a] = BASE >> lvl_q[a];
      if (bus.enable && act_q[a] && !(was_act_q[a] && (dir_q[a] != sgn_q[a]))) begin
        if (tcnt_q[a] >= period[a] - CNT_W'(1)) begin
          tcnt_d[a] = '0;
          if (a == 0) begin
            tilt_raw[3] = sgn_q[0];
            tilt_raw[2] = ~sgn_q[0];
          end else begin
            tilt_raw[0] = sgn_q[1];
            tilt_raw[1] = ~sgn_q[1];
          end
        end else begin
          tcnt_d[a] = tcnt_q[a] + CNT_W'(1);
        end
      end
    end
  end

  // Edge memory is forced low while disabled so a held button re-fires on enable.
  always_comb begin
    bcnt_d  = '0;
    btn_raw = '0;
    bprev_d = bus.enable ? bus.btn : 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (bus.enable && bus.btn[i]) begin
        if (!bprev_q[i]) begin
          btn_raw[i] = 1'b1;
        end else if (bcnt_q[i] == BTN_LIM) begin
          btn_raw[i] = 1'b1;
        end else begin
          bcnt_d[i] = bcnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // OR-merging makes simultaneous button and tilt events a single pulse.
  always_comb begin
    move_d = btn_raw | tilt_raw;
    if (CANCEL_OPP != 0) begin
      if (&move_d[3:2]) move_d[3:2] = 2'b00;
      if (&move_d[1:0]) move_d[1:0] = 2'b00;
    end
    if (!bus.enable) move_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_q     <= '0;
      sgn_q     <= '0;
      lvl_q     <= '0;
      was_act_q <= '0;
      dir_q     <= '0;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      bprev_q   <= '0;
      move_q    <= '0;
    end else begin
      act_q     <= act_d;
      sgn_q     <= sgn_d;
      lvl_q     <= lvl_d;
      was_act_q <= was_act_d;
      dir_q     <= dir_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      bprev_q   <= bprev_d;
      move_q    <= move_d;
    end
  end

  assign bus.move     = move_q;
  assign bus.level_x  = lvl_q[0];
  assign bus.level_y  = lvl_q[1];
  assign bus.tilt_act = {act_q[0], act_q[1]};

endmodule

// File: tb/tb_move_pulse_gen.sv
// tb_move_pulse_gen
//   Self-checking bench for move_pulse_gen with small periods. A behavioural
//   reference model predicts move/level/tilt_act every clock; directed scenarios
//   also check hand-derived pulse positions.
module tb_move_pulse_gen;
  localparam int BTN_P  = 16;
  localparam int BASE_P = 64;
  localparam int DZ     = 8;
  localparam int LSH    = 4;
  localparam int MAXL   = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  move_pulse_gen_if #(.ACC_W(9)) bus();

  move_pulse_gen #(
    .ACC_W(9), .BTN_PERIOD(BTN_P), .BASE_PERIOD(BASE_P), .DEADZONE(DZ),
    .LEVEL_SHIFT(LSH), .MAX_LEVEL(MAXL), .CNT_W(32), .CANCEL_OPP(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: hold time per button, registered tilt view, phase per axis.
  int         m_hold[4];
  bit         m_prev[4];
  bit         m_dact[2];
  int         m_dlvl[2];
  bit         m_dsgn[2];
  bit         m_pact[2];
  bit         m_psgn[2];
  int         m_phase[2];
  logic [3:0] exp_move;
  logic [1:0] exp_lx, exp_ly, exp_act;

  int mags[11] = '{0, 8, 9, 23, 24, 25, 40, 56, 72, 127, 255};

  function automatic int level_of(int mag);
    int l;
    if (mag <= DZ) return 0;
    l = (mag - DZ) / (1 << LSH);
    return (l > MAXL) ? MAXL : l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_hold[i] = 0;
      m_prev[i] = 1'b0;
    end
    for (int a = 0; a < 2; a++) begin
      m_dact[a] = 1'b0; m_dlvl[a] = 0; m_dsgn[a] = 1'b0;
      m_pact[a] = 1'b0; m_psgn[a] = 1'b0; m_phase[a] = 0;
    end
    exp_move = '0; exp_lx = '0; exp_ly = '0; exp_act = '0;
  endtask

  // Predicts the outputs seen after the coming clock edge from the current inputs.
  task automatic model_step();
    logic [3:0] raw;
    logic [8:0] ax[2];
    int mag, idx;
    raw = '0;
    for (int i = 0; i < 4; i++) begin
      if (bus.enable && bus.btn[i]) begin
        m_hold[i] = m_prev[i] ? m_hold[i] + 1 : 0;
        if (m_hold[i] % BTN_P == 0) raw[i] = 1'b1;
      end else begin
        m_hold[i] = 0;
      end
      m_prev[i] = bus.enable && bus.btn[i];
    end
    for (int a = 0; a < 2; a++) begin
      if (bus.enable && m_dact[a] && !(m_pact[a] && (m_psgn[a] != m_dsgn[a]))) begin
        m_phase[a]++;
        if (m_phase[a] >= BASE_P / (1 << m_dlvl[a])) begin
          m_phase[a] = 0;
          if (a == 0) idx = m_dsgn[a] ? 3 : 2;
          else        idx = m_dsgn[a] ? 0 : 1;
          raw[idx] = 1'b1;
        end
      end else begin
        m_phase[a] = 0;
      end
    end
    if (raw[3] && raw[2]) raw[3:2] = 2'b00;
    if (raw[1] && raw[0]) raw[1:0] = 2'b00;
    exp_move = raw;
    ax[0] = bus.accel_x;
    ax[1] = bus.accel_y;
    for (int a = 0; a < 2; a++) begin
      m_pact[a] = m_dact[a];
      m_psgn[a] = m_dsgn[a];
      mag = int'(ax[a][7:0]);
      m_dact[a] = mag > DZ;
      m_dlvl[a] = level_of(mag);
      m_dsgn[a] = ax[a][8];
    end
    exp_lx  = 2'(m_dlvl[0]);
    exp_ly  = 2'(m_dlvl[1]);
    exp_act = {m_dact[0], m_dact[1]};
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] pick_accel();
    logic [7:0] m;
    m = 8'(mags[$urandom_range(0, 10)]);
    return {1'($urandom_range(0, 1)), m};
  endfunction

  task automatic test_reset();
    bus.enable  = 1'b1;
    bus.btn     = 4'b1111;
    bus.accel_x = 9'h148;
    bus.accel_y = 9'h148;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.move !== 4'b0000) begin
      n_err++; $display("[TB] FAIL reset_move: got %b expected 0000", bus.move);
    end
    n_cmp++;
    if (bus.level_x !== 2'd0 || bus.level_y !== 2'd0) begin
      n_err++; $display("[TB] FAIL reset_level: got %0d/%0d expected 0/0", bus.level_x, bus.level_y);
    end
    n_cmp++;
    if (bus.tilt_act !== 2'b00) begin
      n_err++; $display("[TB] FAIL reset_act: got %b expected 00", bus.tilt_act);
    end
    bus.btn = 4'b0000;
    bus.accel_x = 9'h000;
    bus.accel_y = 9'h000;
    #2 reset = 1'b0;
    model_reset();
    repeat (4) tick();
  endtask

  task automatic test_button_repeat();
    logic [3:0] want;
    int pulses = 0;
    bus.btn = 4'b1000;
    for (int k = 0; k < 40; k++) begin
      tick();
      want = (k == 0 || k == 16 || k == 32) ? 4'b1000 : 4'b0000;
      if (bus.move[3]) pulses++;
      n_cmp++;
      if (bus.move !== want) begin
        n_err++; $display("[TB] FAIL t1_repeat k=%0d: got %b expected %b", k, bus.move, want);
      end
      n_cmp++;
      if (bus.move !== exp_move) begin
        n_err++; $display("[TB] FAIL t1_model k=%0d: got %b expected %b", k, bus.move, exp_move);
      end
    end
    bus.btn = 4'b0000;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_cmp++;
      if (bus.move !== 4'b0000) begin
        n_err++; $display("[TB] FAIL t1_release k=%0d: got %b expected 0000", k, bus.move);
      end
    end
    n_cmp++;
    if (pulses != 3) begin
      n_err++; $display("[TB] FAIL t1_count: got %0d expected 3", pulses);
    end
  endtask

  task automatic test_tilt_rate();
    int pulses = 0;
    int first_k = -1;
    bus.accel_x = 9'h10C;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (bus.move[3]) pulses++;
      n_cmp++;
      if (bus.move !== exp_move) begin
        n_err++; $display("[TB] FAIL t2_slow k=%0d: got %b expected %b", k, bus.move, exp_move);
      end
    end
    n_cmp++;
    if (pulses != 3) begin
      n_err++; $display("[TB] FAIL t2_slow_count: got %0d expected 3", pulses);
    end
    pulses = 0;
    bus.accel_x = 9'h148;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (k == 0) begin
        n_cmp++;
        if (bus.level_x !== 2'd3) begin
          n_err++; $display("[TB] FAIL t2_level: got %0d expected 3", bus.level_x);
        end
      end
      if (bus.move[3]) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
      n_cmp++;
      if (bus.move !== exp_move) begin
        n_err++; $display("[TB] FAIL t2_fast k=%0d: got %b expected %b", k, bus.move, exp_move);
      end
    end
    n_cmp++;
    if (first_k != 1 || pulses != 5) begin
      n_err++; $display("[TB] FAIL t2_fast_timing: got first=%0d count=%0d expected first=1 count=5", first_k, pulses);
    end
    bus.accel_x = 9'h000;
    repeat (3) tick();
  endtask

  task automatic test_deadzone();
    int pulses = 0;
    bus.accel_y = 9'h008;
    for (int k = 0; k < 70; k++) begin
      tick();
      n_cmp++;
      if (bus.tilt_act !== 2'b00 || bus.move !== 4'b0000) begin
        n_err++; $display("[TB] FAIL t3_deadzone k=%0d: got act=%b move=%b expected act=00 move=0000", k, bus.tilt_act, bus.move);
      end
    end
    bus.accel_y = 9'h009;
    for (int k = 0; k < 140; k++) begin
      tick();
      if (bus.move[1]) pulses++;
      n_cmp++;
      if (bus.move !== exp_move || bus.tilt_act !== exp_act) begin
        n_err++; $display("[TB] FAIL t3_edge k=%0d: got move=%b act=%b expected move=%b act=%b", k, bus.move, bus.tilt_act, exp_move, exp_act);
      end
    end
    n_cmp++;
    if (pulses != 2) begin
      n_err++; $display("[TB] FAIL t3_count: got %0d expected 2", pulses);
    end
    bus.accel_y = 9'h000;
    repeat (3) tick();
  endtask

  task automatic test_cancel();
    bus.btn = 4'b0100;
    bus.accel_x = 9'h10C;
    for (int k = 0; k < 200; k++) begin
      tick();
      n_cmp++;
      if (bus.move !== exp_move) begin
        n_err++; $display("[TB] FAIL t4_model k=%0d: got %b expected %b", k, bus.move, exp_move);
      end
      if (k == 48 || k == 64) begin
        n_cmp++;
        if (bus.move !== ((k == 48) ? 4'b0100 : 4'b0000)) begin
          n_err++; $display("[TB] FAIL t4_coincide k=%0d: got %b expected %b", k, bus.move, (k == 48) ? 4'b0100 : 4'b0000);
        end
      end
    end
    bus.btn = 4'b0000;
    bus.accel_x = 9'h000;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_count();
    int first_down = -1;
    bus.btn = 4'b1000;
    bus.accel_y = 9'h009;
    repeat (30) tick();
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.move !== 4'b0000 || bus.tilt_act !== 2'b00) begin
      n_err++; $display("[TB] FAIL t5_async: got move=%b act=%b expected 0000/00", bus.move, bus.tilt_act);
    end
    #1 reset = 1'b0;
    model_reset();
    for (int k = 0; k < 80; k++) begin
      tick();
      if (bus.move[1] && first_down < 0) first_down = k;
      if (k == 0) begin
        n_cmp++;
        if (bus.move !== 4'b1000) begin
          n_err++; $display("[TB] FAIL t5_btn_first: got %b expected 1000", bus.move);
        end
      end
      n_cmp++;
      if (bus.move !== exp_move) begin
        n_err++; $display("[TB] FAIL t5_model k=%0d: got %b expected %b", k, bus.move, exp_move);
      end
    end
    n_cmp++;
    if (first_down != 64) begin
      n_err++; $display("[TB] FAIL t5_tilt_first: got %0d expected 64", first_down);
    end
    bus.btn = 4'b0000;
    bus.accel_y = 9'h000;
    repeat (3) tick();
  endtask

  task automatic test_sign_flip();
    logic [3:0] want;
    bus.accel_x = 9'h120;
    repeat (20) tick();
    bus.accel_x = 9'h020;
    for (int k = 0; k < 40; k++) begin
      tick();
      want = (k == 33) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (bus.move !== want) begin
        n_err++; $display("[TB] FAIL t6_flip k=%0d: got %b expected %b", k, bus.move, want);
      end
      n_cmp++;
      if (bus.move !== exp_move) begin
        n_err++; $display("[TB] FAIL t6_model k=%0d: got %b expected %b", k, bus.move, exp_move);
      end
    end
    bus.accel_x = 9'h000;
    repeat (3) tick();
  endtask

  task automatic test_enable();
    bus.enable = 1'b0;
    bus.btn = 4'b0001;
    bus.accel_x = 9'h148;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++;
      if (bus.move !== 4'b0000 || bus.level_x !== 2'd3 || bus.tilt_act !== 2'b10) begin
        n_err++; $display("[TB] FAIL en_off k=%0d: got move=%b lx=%0d act=%b expected 0000/3/10", k, bus.move, bus.level_x, bus.tilt_act);
      end
    end
    bus.enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 0) begin
        n_cmp++;
        if (bus.move !== 4'b0001) begin
          n_err++; $display("[TB] FAIL en_rise: got %b expected 0001", bus.move);
        end
      end
      n_cmp++;
      if (bus.move !== exp_move) begin
        n_err++; $display("[TB] FAIL en_model k=%0d: got %b expected %b", k, bus.move, exp_move);
      end
    end
    bus.btn = 4'b0000;
    bus.accel_x = 9'h000;
    repeat (3) tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 29) == 0) bus.btn = 4'($urandom);
      if ($urandom_range(0, 79) == 0) bus.accel_x = pick_accel();
      if ($urandom_range(0, 79) == 0) bus.accel_y = pick_accel();
      if ($urandom_range(0, 199) == 0) bus.enable = ~bus.enable;
      tick();
      n_cmp++;
      if (bus.move !== exp_move || bus.level_x !== exp_lx || bus.level_y !== exp_ly || bus.tilt_act !== exp_act) begin
        n_err++;
        $display("[TB] FAIL rand k=%0d: got move=%b lx=%0d ly=%0d act=%b expected move=%b lx=%0d ly=%0d act=%b",
                 k, bus.move, bus.level_x, bus.level_y, bus.tilt_act, exp_move, exp_lx, exp_ly, exp_act);
      end
    end
  endtask

  initial begin
    bus.enable  = 1'b1;
    bus.btn     = 4'b0000;
    bus.accel_x = 9'h000;
    bus.accel_y = 9'h000;
    model_reset();
    test_reset();
    test_button_repeat();
    test_tilt_rate();
    test_deadzone();
    test_cancel();
    test_reset_mid_count();
    test_sign_flip();
    test_enable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
